// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO: packs RATIO entries little-endian into
// one wide word on a valid/ready stream, with a flush that emits partial words.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    parameter int CNTW  = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNTW-1:0]        word_cnt,
    output logic                   busy
);

    localparam int              IW   = $clog2(RATIO + 1) + 1;
    localparam logic [IW-1:0]   FULL = IW'(RATIO);

    logic [DSIZE*RATIO-1:0] r_acc;
    logic [IW-1:0]          r_idx;
    logic                   r_rd_pend;
    logic                   r_flush_pend;
    logic [DSIZE*RATIO-1:0] r_out_data;
    logic [RATIO-1:0]       r_out_keep;
    logic                   r_out_valid;
    logic [CNTW-1:0]        r_word_cnt;

    logic                   w_rinc;
    logic                   w_out_free;
    logic                   w_full_emit;
    logic                   w_part_emit;
    logic                   w_emit;
    logic                   w_flush_done;
    logic [RATIO-1:0]       w_part_keep;
    logic [DSIZE*RATIO-1:0] w_acc_next;

    // Reads stop once filled lanes plus the in-flight read cover a whole word,
    // and are held off entirely while reset is applied or a flush is pending.
    assign w_rinc = !rrst && !rempty && !r_flush_pend
                    && ((r_idx + IW'(r_rd_pend)) < FULL);

    assign w_out_free  = !r_out_valid || out_ready;
    assign w_full_emit = (r_idx == FULL) && w_out_free;
    assign w_part_emit = r_flush_pend && !r_rd_pend && (r_idx != '0)
                         && (r_idx < FULL) && w_out_free;
    assign w_emit      = w_full_emit || w_part_emit;

    // A full word waiting during a flush drains through the normal path.
    assign w_flush_done = r_flush_pend && !r_rd_pend
                          && ((r_idx == '0) || w_emit);

    always_comb begin
        w_part_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_part_keep[k] = (IW'(k) < r_idx);
        end
    end

    // Capture and emission are never both possible in one cycle: an
    // outstanding read implies idx was below RATIO when it was issued.
    always_comb begin
        w_acc_next = r_acc;
        if (w_emit) begin
            w_acc_next = '0;
        end else if (r_rd_pend) begin
            for (int k = 0; k < RATIO; k++) begin
                if (r_idx == IW'(k)) begin
                    w_acc_next[k*DSIZE +: DSIZE] = rdata;
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_acc        <= '0;
            r_idx        <= '0;
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc     <= w_acc_next;
            r_rd_pend <= w_rinc;
            if (w_emit) begin
                r_idx <= '0;
            end else if (r_rd_pend) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_flush_done) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Output register holds its word until accepted; a new word may load in
    // the same cycle as the handshake so back-to-back transfers are possible.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            if (w_emit) begin
                r_out_data  <= r_acc;
                r_out_keep  <= w_full_emit ? {RATIO{1'b1}} : w_part_keep;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready) begin
                r_word_cnt <= r_word_cnt + CNTW'(1);
            end
        end
    end

    assign rinc      = w_rinc;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;
    assign word_cnt  = r_word_cnt;
    assign busy      = (r_idx != '0) || r_rd_pend || r_out_valid || r_flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: a queue-based FIFO model feeds the
// packer and a lane scoreboard predicts every delivered word.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;
    localparam int CNTW  = 16;
    localparam int W     = DSIZE * RATIO;

    logic                 rclk = 1'b0;
    logic                 rrst = 1'b1;
    logic                 rempty = 1'b1;
    logic                 rinc;
    logic [DSIZE-1:0]     rdata = '0;
    logic                 flush = 1'b0;
    logic [W-1:0]         out_data;
    logic [RATIO-1:0]     out_keep;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [CNTW-1:0]      word_cnt;
    logic                 busy;

    logic [DSIZE-1:0]     fifoQ[$];
    logic [DSIZE-1:0]     expLanes[$];
    int                   popCount = 0;
    int                   hsCount = 0;
    int                   nChecks = 0;
    int                   nFail = 0;
    logic                 bubble = 1'b0;
    logic                 bubblePhase = 1'b0;
    logic [W-1:0]         lastData = '0;
    logic [RATIO-1:0]     lastKeep = '0;

    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .CNTW(CNTW)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rinc(rinc), .rdata(rdata),
        .flush(flush), .out_data(out_data), .out_keep(out_keep),
        .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt),
        .busy(busy)
    );

    always #5 rclk = ~rclk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Empty flag follows the model queue, optionally forced high every other cycle.
    always @(negedge rclk) begin
        rempty = (fifoQ.size() == 0) || (bubble && bubblePhase);
        bubblePhase = !bubblePhase;
    end

    // FIFO read port: data appears the cycle after rinc. Pops seen by the
    // packer enter the scoreboard; reset discards everything not yet delivered.
    always @(posedge rclk) begin
        if (rinc) begin
            checkOutput("rincWhileEmpty", {63'd0, rempty}, 64'd0);
            if (fifoQ.size() != 0) begin
                logic [DSIZE-1:0] v;
                v = fifoQ.pop_front();
                rdata <= v;
                popCount++;
                if (!rrst) expLanes.push_back(v);
            end
        end
        if (rrst) expLanes.delete();
    end

    // Each handshake takes the oldest lanes: a full word when enough are
    // buffered, otherwise the remainder (only reachable through a flush).
    always @(negedge rclk) begin
        if (!rrst && out_valid && out_ready) begin
            logic [W-1:0]     expData;
            logic [RATIO-1:0] expKeep;
            int               n;
            n = (expLanes.size() >= RATIO) ? RATIO : expLanes.size();
            expData = '0;
            expKeep = '0;
            for (int k = 0; k < n; k++) begin
                expData[k*DSIZE +: DSIZE] = expLanes.pop_front();
                expKeep[k] = 1'b1;
            end
            checkOutput("wordData", 64'(out_data), 64'(expData));
            checkOutput("wordKeep", 64'(out_keep), 64'(expKeep));
            lastData = out_data;
            lastKeep = out_keep;
            hsCount++;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DSIZE-1:0] v);
        fifoQ.push_back(v);
    endtask

    task automatic doReset(input int cycles);
        rrst = 1'b1;
        fifoQ.delete();
        bubble = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
        rrst = 1'b0;
    endtask

    task automatic waitPops(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && popCount < target; i++) tick();
        checkOutput(tag, 64'(popCount), 64'(target));
    endtask

    task automatic waitIdle(input int budget, input string tag);
        for (int i = 0; i < budget && (busy || fifoQ.size() != 0); i++) tick();
        checkOutput(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int base;
        int hsBase;
        int total;
        int pushed;

        // Reset held with data available: nothing may be read.
        tick();
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("resetRinc", {63'd0, rinc}, 64'd0);
            checkOutput("resetBusy", {63'd0, busy}, 64'd0);
        end
        checkOutput("resetValid", {63'd0, out_valid}, 64'd0);
        checkOutput("resetKeep", 64'(out_keep), 64'd0);
        checkOutput("resetCnt", 64'(word_cnt), 64'd0);
        checkOutput("resetPops", 64'(popCount), 64'd0);
        base = popCount;
        rrst = 1'b0;
        #1;
        checkOutput("firstRinc", {63'd0, rinc}, 64'd1);

        // Full word from four entries.
        waitPops(base + 4, 20, "fullPops");
        waitIdle(20, "fullIdle");
        checkOutput("fullRincCount", 64'(popCount - base), 64'd4);
        checkOutput("fullData", 64'(lastData), 64'h44332211);
        checkOutput("fullKeep", 64'(lastKeep), 64'hF);
        checkOutput("fullCnt", 64'(word_cnt), 64'd1);

        // Partial flush of three lanes.
        doReset(2);
        base = popCount;
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        waitPops(base + 3, 20, "partPops");
        repeat (3) tick();
        checkOutput("partNoWord", {63'd0, out_valid}, 64'd0);
        checkOutput("partBusy", {63'd0, busy}, 64'd1);
        pulseFlush();
        waitIdle(20, "partIdle");
        checkOutput("partData", 64'(lastData), 64'h00CCBBAA);
        checkOutput("partKeep", 64'(lastKeep), 64'h7);
        checkOutput("partCnt", 64'(word_cnt), 64'd1);

        // Backpressure: two words buffered, then released in order.
        doReset(2);
        out_ready = 1'b0;
        base = popCount;
        hsBase = hsCount;
        for (int i = 1; i <= 12; i++) applyStimulus(DSIZE'(i));
        repeat (30) tick();
        checkOutput("bpPops", 64'(popCount - base), 64'd8);
        checkOutput("bpValid", {63'd0, out_valid}, 64'd1);
        checkOutput("bpHold", 64'(out_data), 64'h04030201);
        checkOutput("bpHoldKeep", 64'(out_keep), 64'hF);
        out_ready = 1'b1;
        waitIdle(60, "bpIdle");
        checkOutput("bpWords", 64'(hsCount - hsBase), 64'd3);
        checkOutput("bpCnt", 64'(word_cnt), 64'd3);
        checkOutput("bpLast", 64'(lastData), 64'h0C0B0A09);
        checkOutput("bpLeftover", 64'(expLanes.size()), 64'd0);

        // Empty bubbles during a word.
        doReset(2);
        bubble = 1'b1;
        base = popCount;
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        waitPops(base + 4, 40, "bubPops");
        waitIdle(20, "bubIdle");
        bubble = 1'b0;
        checkOutput("bubData", 64'(lastData), 64'h44332211);
        checkOutput("bubKeep", 64'(lastKeep), 64'hF);
        checkOutput("bubCnt", 64'(word_cnt), 64'd1);

        // Flush with nothing accumulated.
        doReset(2);
        pulseFlush();
        checkOutput("flush0Pend", {63'd0, busy}, 64'd1);
        tick();
        checkOutput("flush0Clear", {63'd0, busy}, 64'd0);
        checkOutput("flush0Valid", {63'd0, out_valid}, 64'd0);
        checkOutput("flush0Cnt", 64'(word_cnt), 64'd0);

        // Flush arriving while the second read is in flight with idx=1.
        doReset(2);
        base = popCount;
        applyStimulus(8'h5A); applyStimulus(8'h6B);
        waitPops(base + 2, 20, "fpPops");
        pulseFlush();
        waitIdle(20, "fpIdle");
        checkOutput("fpKeep", 64'(lastKeep), 64'h3);
        checkOutput("fpData", 64'(lastData), 64'h00006B5A);
        checkOutput("fpCnt", 64'(word_cnt), 64'd1);

        // Reset mid-word discards the accumulated lanes.
        doReset(2);
        base = popCount;
        applyStimulus(8'h21); applyStimulus(8'h32);
        waitPops(base + 2, 20, "rmPops");
        tick();
        checkOutput("rmBusy", {63'd0, busy}, 64'd1);
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        checkOutput("rmCleared", {63'd0, busy}, 64'd0);
        base = popCount;
        applyStimulus(8'h41); applyStimulus(8'h52);
        applyStimulus(8'h63); applyStimulus(8'h74);
        waitPops(base + 4, 20, "rmPops2");
        waitIdle(20, "rmIdle");
        checkOutput("rmData", 64'(lastData), 64'h74635241);
        checkOutput("rmKeep", 64'(lastKeep), 64'hF);
        checkOutput("rmCnt", 64'(word_cnt), 64'd1);

        // Random supply and random backpressure, closed by a flush.
        doReset(2);
        total = $urandom_range(30, 50);
        pushed = 0;
        for (int i = 0; i < 2000 && pushed < total; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(DSIZE'($urandom_range(0, 255)));
                pushed++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 200 && fifoQ.size() != 0; i++) tick();
        repeat (10) tick();
        checkOutput("rndRemainder", 64'(expLanes.size()), 64'(total % RATIO));
        checkOutput("rndFullWords", 64'(word_cnt), 64'(total / RATIO));
        pulseFlush();
        waitIdle(20, "rndIdle");
        checkOutput("rndCnt", 64'(word_cnt), 64'((total + RATIO - 1) / RATIO));
        checkOutput("rndDrained", 64'(expLanes.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
